bcd_conv_scheduler: RTL

//  Shares one iterative binary-to-BCD converter (start/done interface) between NUM_REQ requesters.

---
 rtl/bcd_conv_scheduler_if.sv | 32 +++
 rtl/bcd_conv_scheduler.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bcd_conv_scheduler_if.sv
// Requester-side and converter-side signals of the shared BCD converter scheduler.
// The slave modport is the scheduler; the master modport is the environment.
interface bcd_conv_scheduler_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned BCD_DIGITS = 3
);
  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;

  logic [NUM_REQ-1:0]       i_Req;
  logic [NUM_REQ*BIN_W-1:0] i_Bin;
  logic [NUM_REQ-1:0]       o_Ack;
  logic [BCD_W-1:0]         o_BCD;
  logic [GID_W-1:0]         o_Grant_Id;
  logic                     o_Busy;
  logic                     o_Err;
  logic                     o_Conv_Start;
  logic [BIN_W-1:0]         o_Conv_Bin;
  logic                     i_Conv_Done;
  logic [BCD_W-1:0]         i_Conv_BCD;

  modport slave (
    input  i_Req, i_Bin, i_Conv_Done, i_Conv_BCD,
    output o_Ack, o_BCD, o_Grant_Id, o_Busy, o_Err, o_Conv_Start, o_Conv_Bin
  );

  modport master (
    output i_Req, i_Bin, i_Conv_Done, i_Conv_BCD,
    input  o_Ack, o_BCD, o_Grant_Id, o_Busy, o_Err, o_Conv_Start, o_Conv_Bin
  );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one iterative binary-to-BCD converter between requesters,
// with a watchdog that abandons a conversion and flags a sticky error.
module bcd_conv_scheduler #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned BCD_DIGITS = 3,
  parameter int unsigned TIMEOUT    = 31
) (
  input logic                i_Clk,
  input logic                i_Rst,
  bcd_conv_scheduler_if.slave bus
);
  localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  localparam logic [GID_W:0]   NUM_REQ_W = (GID_W+1)'(NUM_REQ);
  localparam logic [GID_W-1:0] LAST_ID   = GID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t             state;
  logic [GID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] ack_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [GID_W-1:0]   grant_q;
  logic               busy_q;
  logic               err_q;
  logic               start_q;
  logic [BIN_W-1:0]   bin_q;

  logic [GID_W-1:0]   cand [NUM_REQ];
  logic [BIN_W-1:0]   bin_arr [NUM_REQ];
  logic               pick_valid;
  logic [GID_W-1:0]   pick_id;

  // Candidate k is the requester k places after the rr pointer, modulo NUM_REQ.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
    logic [GID_W:0] sum;
    assign sum        = {1'b0, rr_ptr} + (GID_W+1)'(g);
    assign cand[g]    = (sum >= NUM_REQ_W) ? GID_W'(sum - NUM_REQ_W) : GID_W'(sum);
    assign bin_arr[g] = bus.i_Bin[g*BIN_W +: BIN_W];
  end

  // First requesting candidate wins; scanning downward leaves the nearest one assigned last.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.i_Req[cand[i]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[i];
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      ack_q   <= '0;
      bcd_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_id;
            bin_q   <= bin_arr[pick_id];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          start_q <= 1'b0;
          cnt     <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_Conv_Done) begin
            bcd_q <= bus.i_Conv_BCD;
            ack_q <= NUM_REQ'(1) << grant_q;
            state <= S_DELIVER;
          end else if (cnt == TO_LAST) begin
            // Abandoned conversion: deliver an all-F result so the display shows the fault.
            bcd_q <= '1;
            err_q <= 1'b1;
            ack_q <= NUM_REQ'(1) << grant_q;
            state <= S_DELIVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          ack_q  <= '0;
          busy_q <= 1'b0;
          rr_ptr <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Ack        = ack_q;
  assign bus.o_BCD        = bcd_q;
  assign bus.o_Grant_Id   = grant_q;
  assign bus.o_Busy       = busy_q;
  assign bus.o_Err        = err_q;
  assign bus.o_Conv_Start = start_q;
  assign bus.o_Conv_Bin   = bin_q;
endmodule
